// File: rtl/hdma_engine_if.sv
// ---------------------------------------------------------------------------
// hdma_engine_if
//   Bus bundle between the VRAM DMA engine and its two memories:
//   the CPU-bus read port (source) and the VRAM write port (destination).
//
//   Signals
//     src_addr   [15:0]  CPU-bus read address
//     src_rd             read strobe; src_data is valid on the following cycle
//     src_data   [7:0]   read data returned by the CPU bus
//     vram_addr  [12:0]  VRAM byte offset
//     vram_wr            VRAM write strobe
//     vram_data  [7:0]   VRAM write data
//
//   Handshake: both ports are strobe-only, with no back-pressure. A read is
//   issued for exactly one cycle with src_rd=1 and the slave must present
//   src_data on the very next cycle. A write is one cycle with vram_wr=1;
//   addr/data are meaningful only in that cycle.
//
//   Modports
//     master : the DMA engine
//     slave  : the memory side (CPU bus + VRAM)
// ---------------------------------------------------------------------------
interface hdma_engine_if;
   logic [15:0] src_addr;
   logic        src_rd;
   logic [7:0]  src_data;
   logic [12:0] vram_addr;
   logic        vram_wr;
   logic [7:0]  vram_data;

   modport master (
      output src_addr, src_rd, vram_addr, vram_wr, vram_data,
      input  src_data
   );

   modport slave (
      input  src_addr, src_rd, vram_addr, vram_wr, vram_data,
      output src_data
   );
endinterface

// File: rtl/hdma_engine.sv
// ---------------------------------------------------------------------------
// hdma_engine
//   CGB VRAM DMA engine. Copies 16-byte blocks from the CPU bus into VRAM,
//   either all at once (GDMA) or one block per HBlank entry (HDMA). The CPU
//   is stalled while a block is in flight. Each byte takes two cycles
//   (read, then write), so one block occupies 32 back-to-back cycles.
//
//   Ports
//     clk4_2         system clock, rising edge
//     reset_n        asynchronous active-low reset
//     DMA_start      1-cycle pulse, HDMA1..5 are valid in that cycle
//     HDMA1..HDMA4   source hi/lo, destination hi/lo
//     HDMA5          [7] mode (0 GDMA, 1 HDMA), [6:0] blocks-1
//     STAT_mode      PPU mode, 2'b00 = HBlank
//     bus            source read / VRAM write port (master side)
//     cpu_stall      high while a block is being copied
//     GDMA_finished  1-cycle pulse the cycle after the final write
//     hdma_status    FF55 readback value
//     o_dbg_state    current FSM state
// ---------------------------------------------------------------------------
module hdma_engine (
   input  logic          clk4_2,
   input  logic          reset_n,
   input  logic          DMA_start,
   input  logic [7:0]    HDMA1,
   input  logic [7:0]    HDMA2,
   input  logic [7:0]    HDMA3,
   input  logic [7:0]    HDMA4,
   input  logic [7:0]    HDMA5,
   input  logic [1:0]    STAT_mode,
   hdma_engine_if.master bus,
   output logic          cpu_stall,
   output logic          GDMA_finished,
   output logic [7:0]    hdma_status,
   output logic [2:0]    o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GDMA_RD   = 3'd1,
      S_GDMA_WR   = 3'd2,
      S_HDMA_WAIT = 3'd3,
      S_HDMA_RD   = 3'd4,
      S_HDMA_WR   = 3'd5,
      S_HDMA_HOLD = 3'd6
   } state_t;

   state_t      r_state;
   logic [1:0]  r_stat_prev;
   logic [15:0] r_src;
   logic [12:0] r_dst;
   logic [7:0]  r_blk_left;
   logic [3:0]  r_byte;
   logic        r_src_rd;
   logic        r_vram_wr;
   logic        r_stall;
   logic        r_fin;
   logic [7:0]  r_status;

   // A start that arrives while a block is being copied is parked here and
   // acted on at the block boundary, so a block is never split.
   logic        r_pend;
   logic        r_pend_mode;
   logic [15:0] r_pend_src;
   logic [12:0] r_pend_dst;
   logic [6:0]  r_pend_n;

   logic        w_hblank_start;
   logic [15:0] w_new_src;
   logic [12:0] w_new_dst;
   logic        w_pv;
   logic        w_ld_mode;
   logic [15:0] w_ld_src;
   logic [12:0] w_ld_dst;
   logic [6:0]  w_ld_n;
   logic [7:0]  w_ld_blk;
   logic [7:0]  w_blk_dec;
   logic [6:0]  w_left_m1;
   logic [6:0]  w_left_m2;
   logic        w_last_byte;
   logic        w_in_copy;
   logic        w_do_load;
   logic        w_unused;

   assign w_hblank_start = (STAT_mode == 2'b00) && (r_stat_prev != 2'b00);
   assign w_new_src      = {HDMA1, HDMA2[7:4], 4'h0};
   assign w_new_dst      = {HDMA3[4:0], HDMA4[7:4], 4'h0};

   // Parameters to load: a live start wins over a parked one.
   assign w_pv      = r_pend | DMA_start;
   assign w_ld_mode = DMA_start ? HDMA5[7]   : r_pend_mode;
   assign w_ld_src  = DMA_start ? w_new_src  : r_pend_src;
   assign w_ld_dst  = DMA_start ? w_new_dst  : r_pend_dst;
   assign w_ld_n    = DMA_start ? HDMA5[6:0] : r_pend_n;
   assign w_ld_blk  = {1'b0, w_ld_n} + 8'd1;

   // blk_left is 1..128; its 7-bit "minus one" form is the FF55 count field.
   assign w_blk_dec   = r_blk_left - 8'd1;
   assign w_left_m1   = r_blk_left[6:0] - 7'd1;
   assign w_left_m2   = r_blk_left[6:0] - 7'd2;
   assign w_last_byte = (r_byte == 4'hF);
   assign w_in_copy   = (r_state == S_HDMA_RD) || (r_state == S_HDMA_WR);

   assign w_do_load =
      ((r_state == S_IDLE) && DMA_start) ||
      (((r_state == S_HDMA_WAIT) || (r_state == S_HDMA_HOLD)) && DMA_start && HDMA5[7]) ||
      ((r_state == S_HDMA_WR) && w_last_byte && w_pv && w_ld_mode);

   assign w_unused = &{1'b0, HDMA2[3:0], HDMA3[7:5], HDMA4[3:0]};

   always_ff @(posedge clk4_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_stat_prev <= 2'b00;
         r_src       <= '0;
         r_dst       <= '0;
         r_blk_left  <= '0;
         r_byte      <= '0;
         r_src_rd    <= 1'b0;
         r_vram_wr   <= 1'b0;
         r_stall     <= 1'b0;
         r_fin       <= 1'b0;
         r_status    <= 8'hFF;
         r_pend      <= 1'b0;
         r_pend_mode <= 1'b0;
         r_pend_src  <= '0;
         r_pend_dst  <= '0;
         r_pend_n    <= '0;
      end else begin
         r_stat_prev <= STAT_mode;
         r_fin       <= 1'b0;

         if (DMA_start && w_in_copy) begin
            r_pend      <= 1'b1;
            r_pend_mode <= HDMA5[7];
            r_pend_src  <= w_new_src;
            r_pend_dst  <= w_new_dst;
            r_pend_n    <= HDMA5[6:0];
         end

         case (r_state)
            S_IDLE: begin
               if (DMA_start) begin
                  r_pend <= 1'b0;
                  if (HDMA5[7]) begin
                     r_state <= S_HDMA_WAIT;
                  end else begin
                     r_state  <= S_GDMA_RD;
                     r_src_rd <= 1'b1;
                     r_stall  <= 1'b1;
                  end
               end
            end

            S_GDMA_RD: begin
               r_src_rd  <= 1'b0;
               r_vram_wr <= 1'b1;
               r_state   <= S_GDMA_WR;
            end

            S_GDMA_WR: begin
               r_vram_wr <= 1'b0;
               r_src     <= r_src + 16'd1;
               r_dst     <= r_dst + 13'd1;
               r_byte    <= r_byte + 4'd1;
               if (w_last_byte) begin
                  r_blk_left <= w_blk_dec;
                  r_status   <= {1'b0, w_left_m2};
               end
               if (w_last_byte && (w_blk_dec == 8'd0)) begin
                  r_state  <= S_IDLE;
                  r_stall  <= 1'b0;
                  r_fin    <= 1'b1;
                  r_status <= 8'hFF;
               end else begin
                  r_state  <= S_GDMA_RD;
                  r_src_rd <= 1'b1;
               end
            end

            S_HDMA_WAIT, S_HDMA_HOLD: begin
               if (DMA_start) begin
                  if (HDMA5[7]) begin
                     r_state <= S_HDMA_WAIT;
                  end else begin
                     r_state  <= S_IDLE;
                     r_status <= {1'b1, w_left_m1};
                  end
               end else if (r_state == S_HDMA_WAIT) begin
                  if (w_hblank_start) begin
                     r_state  <= S_HDMA_RD;
                     r_src_rd <= 1'b1;
                     r_stall  <= 1'b1;
                  end
               end else if (STAT_mode != 2'b00) begin
                  // Leaving HBlank re-arms the wait: one block per HBlank.
                  r_state <= S_HDMA_WAIT;
               end
            end

            S_HDMA_RD: begin
               r_src_rd  <= 1'b0;
               r_vram_wr <= 1'b1;
               r_state   <= S_HDMA_WR;
            end

            S_HDMA_WR: begin
               r_vram_wr <= 1'b0;
               r_src     <= r_src + 16'd1;
               r_dst     <= r_dst + 13'd1;
               r_byte    <= r_byte + 4'd1;
               if (!w_last_byte) begin
                  r_state  <= S_HDMA_RD;
                  r_src_rd <= 1'b1;
               end else begin
                  r_blk_left <= w_blk_dec;
                  r_stall    <= 1'b0;
                  r_pend     <= 1'b0;
                  // Boundary priority: parked restart, then natural
                  // completion, then parked cancel, else wait for next HBlank.
                  if (w_pv && w_ld_mode) begin
                     r_state <= S_HDMA_WAIT;
                  end else if (w_blk_dec == 8'd0) begin
                     r_state  <= S_IDLE;
                     r_fin    <= 1'b1;
                     r_status <= 8'hFF;
                  end else if (w_pv) begin
                     r_state  <= S_IDLE;
                     r_status <= {1'b1, w_left_m2};
                  end else begin
                     r_state  <= S_HDMA_HOLD;
                     r_status <= {1'b0, w_left_m2};
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase

         // Loading a new transfer overrides the pointer/count updates above.
         if (w_do_load) begin
            r_src      <= w_ld_src;
            r_dst      <= w_ld_dst;
            r_blk_left <= w_ld_blk;
            r_byte     <= 4'h0;
            r_status   <= {1'b0, w_ld_n};
         end
      end
   end

   assign bus.src_addr  = r_src;
   assign bus.src_rd    = r_src_rd;
   assign bus.vram_addr = r_dst;
   assign bus.vram_wr   = r_vram_wr;
   // Read data arrives in the write cycle itself, so it is passed straight
   // through and held at zero outside write cycles.
   assign bus.vram_data = r_vram_wr ? bus.src_data : 8'h00;
   assign cpu_stall     = r_stall;
   assign GDMA_finished = r_fin;
   assign hdma_status   = r_status;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_hdma_engine.sv
// ---------------------------------------------------------------------------
// tb_hdma_engine
//   Directed bench for hdma_engine: GDMA, HDMA pacing, cancel, address wrap,
//   same-cycle start/HBlank, and reset during a transfer.
// ---------------------------------------------------------------------------
module tb_hdma_engine;

   logic       clk;
   logic       rst_n;
   logic       dma_start;
   logic [7:0] hdma1, hdma2, hdma3, hdma4, hdma5;
   logic [1:0] stat_mode;
   logic       cpu_stall;
   logic       gdma_finished;
   logic [7:0] hdma_status;
   logic [2:0] dbg_state;

   hdma_engine_if bus ();

   hdma_engine dut (
      .clk4_2        (clk),
      .reset_n       (rst_n),
      .DMA_start     (dma_start),
      .HDMA1         (hdma1),
      .HDMA2         (hdma2),
      .HDMA3         (hdma3),
      .HDMA4         (hdma4),
      .HDMA5         (hdma5),
      .STAT_mode     (stat_mode),
      .bus           (bus.master),
      .cpu_stall     (cpu_stall),
      .GDMA_finished (gdma_finished),
      .hdma_status   (hdma_status),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- source memory model ----------------
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   initial bus.src_data = 8'h00;
   always @(posedge clk) begin
      if (bus.src_rd) bus.src_data <= mem_f(bus.src_addr);
   end

   // ---------------- monitor / scoreboard capture ----------------
   logic [20:0] act_q[$];
   logic [20:0] exp_q[$];
   logic [15:0] rd_q[$];
   int cyc = 0;
   int stall_cnt = 0;
   int fin_cnt = 0;
   int last_wr_cyc = 0;
   int fin_cyc = 0;

   always @(negedge clk) begin
      if (bus.vram_wr) begin
         act_q.push_back({bus.vram_addr, bus.vram_data});
         last_wr_cyc = cyc;
      end
      if (bus.src_rd) rd_q.push_back(bus.src_addr);
      if (cpu_stall) stall_cnt++;
      if (gdma_finished) begin
         fin_cnt++;
         fin_cyc = cyc;
      end
      cyc = cyc + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_sb();
      act_q.delete();
      exp_q.delete();
      rd_q.delete();
      stall_cnt = 0;
      fin_cnt   = 0;
   endtask

   task automatic dma_go(input logic [7:0] h1, h2, h3, h4, h5);
      hdma1 = h1; hdma2 = h2; hdma3 = h3; hdma4 = h4; hdma5 = h5;
      dma_start = 1'b1;
      tick();
      dma_start = 1'b0;
   endtask

   task automatic wait_fin(input int budget);
      for (int i = 0; i < budget && fin_cnt == 0; i++) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      ticks(2);
      checks++; if (bus.src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd got %b exp 0", bus.src_rd); end
      checks++; if (bus.vram_wr !== 1'b0) begin errors++; $display("FAIL reset_vram_wr got %b exp 0", bus.vram_wr); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
      checks++; if (gdma_finished !== 1'b0) begin errors++; $display("FAIL reset_fin got %b exp 0", gdma_finished); end
      checks++; if (bus.src_addr !== 16'h0000) begin errors++; $display("FAIL reset_src_addr got %h exp 0000", bus.src_addr); end
      checks++; if (bus.vram_addr !== 13'h0000) begin errors++; $display("FAIL reset_vram_addr got %h exp 0000", bus.vram_addr); end
      checks++; if (hdma_status !== 8'hFF) begin errors++; $display("FAIL reset_status got %h exp ff", hdma_status); end
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      rst_n = 1'b1;
      ticks(2);
   endtask

   task automatic test_gdma();
      logic [12:0] a;
      logic [15:0] s;
      clear_sb();
      dma_go(8'h12, 8'h34, 8'h81, 8'h20, 8'h00);
      wait_fin(100);
      ticks(3);
      for (int i = 0; i < 16; i++) begin
         a = 13'h0120 + 13'(i);
         s = 16'h1230 + 16'(i);
         exp_q.push_back({a, mem_f(s)});
      end
      checks++; if (act_q.size() != 16) begin errors++; $display("FAIL gdma_wr_count got %0d exp 16", act_q.size()); end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL gdma_wr[%0d] got %h exp %h", i, act_q[i], exp_q[i]); end
      end
      checks++; if (rd_q.size() != 16) begin errors++; $display("FAIL gdma_rd_count got %0d exp 16", rd_q.size()); end
      for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
         s = 16'h1230 + 16'(i);
         checks++; if (rd_q[i] !== s) begin errors++; $display("FAIL gdma_rd[%0d] got %h exp %h", i, rd_q[i], s); end
      end
      checks++; if (stall_cnt != 32) begin errors++; $display("FAIL gdma_stall_cycles got %0d exp 32", stall_cnt); end
      checks++; if (fin_cnt != 1) begin errors++; $display("FAIL gdma_fin_count got %0d exp 1", fin_cnt); end
      checks++; if (fin_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL gdma_fin_timing got %0d exp %0d", fin_cyc, last_wr_cyc + 1); end
      checks++; if (hdma_status !== 8'hFF) begin errors++; $display("FAIL gdma_status got %h exp ff", hdma_status); end
   endtask

   task automatic test_hdma();
      logic [12:0] a;
      clear_sb();
      stat_mode = 2'd3;
      ticks(2);
      dma_go(8'h40, 8'h00, 8'h08, 8'h00, 8'h81);
      ticks(50);
      checks++; if (act_q.size() != 0) begin errors++; $display("FAIL hdma_early_writes got %0d exp 0", act_q.size()); end
      checks++; if (stall_cnt != 0) begin errors++; $display("FAIL hdma_wait_stall got %0d exp 0", stall_cnt); end
      checks++; if (hdma_status !== 8'h01) begin errors++; $display("FAIL hdma_status_start got %h exp 01", hdma_status); end
      stat_mode = 2'd0;
      ticks(40);
      checks++; if (act_q.size() != 16) begin errors++; $display("FAIL hdma_blk1_count got %0d exp 16", act_q.size()); end
      checks++; if (hdma_status !== 8'h00) begin errors++; $display("FAIL hdma_status_blk1 got %h exp 00", hdma_status); end
      ticks(200);
      checks++; if (act_q.size() != 16) begin errors++; $display("FAIL hdma_one_per_hblank got %0d exp 16", act_q.size()); end
      checks++; if (fin_cnt != 0) begin errors++; $display("FAIL hdma_early_fin got %0d exp 0", fin_cnt); end
      stat_mode = 2'd3;
      ticks(10);
      stat_mode = 2'd0;
      wait_fin(60);
      ticks(3);
      for (int i = 0; i < 32; i++) begin
         a = 13'h0800 + 13'(i);
         exp_q.push_back({a, mem_f(16'h4000 + 16'(i))});
      end
      checks++; if (act_q.size() != 32) begin errors++; $display("FAIL hdma_total_count got %0d exp 32", act_q.size()); end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL hdma_wr[%0d] got %h exp %h", i, act_q[i], exp_q[i]); end
      end
      checks++; if (stall_cnt != 64) begin errors++; $display("FAIL hdma_stall_cycles got %0d exp 64", stall_cnt); end
      checks++; if (fin_cnt != 1) begin errors++; $display("FAIL hdma_fin_count got %0d exp 1", fin_cnt); end
      checks++; if (hdma_status !== 8'hFF) begin errors++; $display("FAIL hdma_status_end got %h exp ff", hdma_status); end
   endtask

   task automatic test_cancel();
      clear_sb();
      stat_mode = 2'd3;
      ticks(2);
      dma_go(8'h50, 8'h00, 8'h04, 8'h00, 8'h83);
      checks++; if (hdma_status !== 8'h03) begin errors++; $display("FAIL cancel_status_start got %h exp 03", hdma_status); end
      stat_mode = 2'd0;
      ticks(40);
      checks++; if (hdma_status !== 8'h02) begin errors++; $display("FAIL cancel_status_blk1 got %h exp 02", hdma_status); end
      stat_mode = 2'd3;
      ticks(5);
      dma_go(8'h50, 8'h00, 8'h04, 8'h00, 8'h00);
      checks++; if (hdma_status !== 8'h82) begin errors++; $display("FAIL cancel_status got %h exp 82", hdma_status); end
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL cancel_state got %0d exp 0", dbg_state); end
      ticks(3);
      stat_mode = 2'd0;
      ticks(60);
      checks++; if (act_q.size() != 16) begin errors++; $display("FAIL cancel_writes got %0d exp 16", act_q.size()); end
      checks++; if (fin_cnt != 0) begin errors++; $display("FAIL cancel_fin got %0d exp 0", fin_cnt); end
      checks++; if (hdma_status !== 8'h82) begin errors++; $display("FAIL cancel_status_hold got %h exp 82", hdma_status); end
   endtask

   task automatic test_wrap();
      logic [12:0] a;
      logic [15:0] s;
      clear_sb();
      dma_go(8'hFF, 8'hF0, 8'h1F, 8'hF0, 8'h01);
      wait_fin(120);
      ticks(3);
      for (int i = 0; i < 32; i++) begin
         a = 13'h1FF0 + 13'(i);
         s = 16'hFFF0 + 16'(i);
         exp_q.push_back({a, mem_f(s)});
      end
      checks++; if (act_q.size() != 32) begin errors++; $display("FAIL wrap_count got %0d exp 32", act_q.size()); end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_wr[%0d] got %h exp %h", i, act_q[i], exp_q[i]); end
      end
      checks++; if (rd_q.size() > 16 && rd_q[16] !== 16'h0000) begin errors++; $display("FAIL wrap_src got %h exp 0000", rd_q[16]); end
      checks++; if (fin_cnt != 1) begin errors++; $display("FAIL wrap_fin got %0d exp 1", fin_cnt); end
   endtask

   task automatic test_same_cycle_start();
      logic [12:0] a;
      clear_sb();
      stat_mode = 2'd3;
      ticks(3);
      stat_mode = 2'd0;
      dma_go(8'h20, 8'h00, 8'h03, 8'h00, 8'h80);
      ticks(60);
      checks++; if (act_q.size() != 0) begin errors++; $display("FAIL same_cycle_early got %0d exp 0", act_q.size()); end
      stat_mode = 2'd3;
      ticks(5);
      stat_mode = 2'd0;
      wait_fin(60);
      ticks(3);
      for (int i = 0; i < 16; i++) begin
         a = 13'h0300 + 13'(i);
         exp_q.push_back({a, mem_f(16'h2000 + 16'(i))});
      end
      checks++; if (act_q.size() != 16) begin errors++; $display("FAIL same_cycle_count got %0d exp 16", act_q.size()); end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL same_cycle_wr[%0d] got %h exp %h", i, act_q[i], exp_q[i]); end
      end
      checks++; if (fin_cnt != 1) begin errors++; $display("FAIL same_cycle_fin got %0d exp 1", fin_cnt); end
      checks++; if (hdma_status !== 8'hFF) begin errors++; $display("FAIL same_cycle_status got %h exp ff", hdma_status); end
   endtask

   task automatic test_reset_mid_gdma();
      clear_sb();
      stat_mode = 2'd3;
      dma_go(8'h30, 8'h00, 8'h05, 8'h00, 8'h02);
      for (int i = 0; i < 40 && act_q.size() < 7; i++) tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (act_q.size() != 7) begin errors++; $display("FAIL rst_mid_progress got %0d exp 7", act_q.size()); end
      checks++; if (bus.src_rd !== 1'b0) begin errors++; $display("FAIL rst_mid_src_rd got %b exp 0", bus.src_rd); end
      checks++; if (bus.vram_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_vram_wr got %b exp 0", bus.vram_wr); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", cpu_stall); end
      checks++; if (bus.src_addr !== 16'h0000) begin errors++; $display("FAIL rst_mid_src_addr got %h exp 0000", bus.src_addr); end
      checks++; if (bus.vram_addr !== 13'h0000) begin errors++; $display("FAIL rst_mid_vram_addr got %h exp 0000", bus.vram_addr); end
      checks++; if (bus.vram_data !== 8'h00) begin errors++; $display("FAIL rst_mid_vram_data got %h exp 00", bus.vram_data); end
      checks++; if (hdma_status !== 8'hFF) begin errors++; $display("FAIL rst_mid_status got %h exp ff", hdma_status); end
      ticks(3);
      rst_n = 1'b1;
      ticks(60);
      checks++; if (act_q.size() != 7) begin errors++; $display("FAIL rst_mid_resume got %0d exp 7", act_q.size()); end
      checks++; if (fin_cnt != 0) begin errors++; $display("FAIL rst_mid_fin got %0d exp 0", fin_cnt); end
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", dbg_state); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst_n     = 1'b0;
      dma_start = 1'b0;
      hdma1 = 8'h00; hdma2 = 8'h00; hdma3 = 8'h00; hdma4 = 8'h00; hdma5 = 8'h00;
      stat_mode = 2'd3;
      test_reset();
      test_gdma();
      test_hdma();
      test_cancel();
      test_wrap();
      test_same_cycle_start();
      test_reset_mid_gdma();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
